// File: rtl/flo_bitmap_sched.sv
// -----------------------------------------------------------------------------
// flo_bitmap_sched
//   Highest-index-first scheduler over a WID-bit pending bitmap. One shared
//   find-last-one unit scans one SLICE-bit slice per clock, top slice first.
//   The winning index is offered on a valid/ready grant port; on acceptance the
//   bit is cleared and the scan restarts from the top slice.
//
// Ports
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous reset, active low
//   ld       : replace bitmap with ld_map (pulse), restarts scan
//   ld_map   : new bitmap contents
//   set_vld  : OR one request bit (set_idx) into the bitmap
//   set_idx  : bit to set; values >= WID are ignored
//   gnt_vld  : grant valid (registered)
//   gnt_idx  : granted bit index (registered, stable while gnt_vld)
//   gnt_rdy  : consumer accepts grant when gnt_vld & gnt_rdy
//   busy     : state is not IDLE (decoded from state register)
//   empty    : bitmap register is all zero (decoded from bitmap register)
// -----------------------------------------------------------------------------

// Find-last-one over a 144-bit vector: position of the highest set bit,
// or 255 when no bit is set.
module flo144 (
  input  logic [143:0] vec_i,
  output logic [7:0]   pos_o
);

  localparam int unsigned VW   = 144;
  localparam int unsigned GRP  = 8;
  localparam int unsigned NGRP = VW / GRP;

  logic [NGRP-1:0] grp_any;
  logic [2:0]      grp_pos [NGRP];

  // Per 8-bit group: any-bit flag and local highest position.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_any[g] = |vec_i[g*GRP +: GRP];
      grp_pos[g] = 3'd0;
      for (int b = 0; b < GRP; b++) begin
        if (vec_i[g*GRP + b]) grp_pos[g] = 3'(b);
      end
    end
  end

  // Highest non-empty group wins; combine group number and local position.
  always_comb begin
    pos_o = 8'hFF;
    for (int g = 0; g < NGRP; g++) begin
      if (grp_any[g]) pos_o = {5'(g), grp_pos[g]};
    end
  end

endmodule

module flo_bitmap_sched #(
  parameter int unsigned WID    = 576,
  parameter int unsigned SLICE  = 144,
  parameter int unsigned NSLICE = 4,
  parameter int unsigned IW     = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld,
  input  logic [WID-1:0] ld_map,
  input  logic           set_vld,
  input  logic [IW-1:0]  set_idx,
  output logic           gnt_vld,
  output logic [IW-1:0]  gnt_idx,
  input  logic           gnt_rdy,
  output logic           busy,
  output logic           empty
);

  localparam int unsigned PW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned RW       = 8;
  localparam logic [RW-1:0] NONE   = 8'hFF;
  localparam logic [PW-1:0] PTR_TOP = PW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WID-1:0]  map_q, map_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;

  logic [SLICE-1:0] slice_a [NSLICE];
  logic [SLICE-1:0] cur_slice;
  logic [RW-1:0]    flo_pos;
  logic             accept;

  // Split bitmap into slices so the scan mux is indexed by ptr directly.
  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    assign slice_a[g] = map_q[g*SLICE +: SLICE];
  end

  assign cur_slice = slice_a[ptr_q];

  flo144 u_flo (
    .vec_i (cur_slice),
    .pos_o (flo_pos)
  );

  assign accept = gnt_vld_q & gnt_rdy;

  // Bitmap update: ld overrides; otherwise clear-on-accept then set, so a
  // same-bit set beats the clear.
  always_comb begin
    map_d = map_q;
    if (ld) begin
      map_d = ld_map;
    end else begin
      if (accept) map_d[gnt_idx_q] = 1'b0;
      if (set_vld && (set_idx < IW'(WID))) map_d[set_idx] = 1'b1;
    end
  end

  // Next-state and grant register logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|map_q) begin
          state_d = ST_SCAN;
          ptr_d   = PTR_TOP;
        end
      end
      ST_SCAN: begin
        if (flo_pos != NONE) begin
          gnt_idx_d = IW'(ptr_q) * IW'(SLICE) + IW'(flo_pos);
          gnt_vld_d = 1'b1;
          state_d   = ST_PRESENT;
        end else if (ptr_q != '0) begin
          ptr_d = ptr_q - PW'(1);
        end else begin
          state_d = ST_IDLE;
          ptr_d   = PTR_TOP;
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          gnt_vld_d = 1'b0;
          ptr_d     = PTR_TOP;
          state_d   = ST_SCAN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ptr_d     = PTR_TOP;
        gnt_vld_d = 1'b0;
      end
    endcase

    // A load restarts the scan from the top regardless of state.
    if (ld) begin
      gnt_vld_d = 1'b0;
      ptr_d     = PTR_TOP;
      state_d   = ST_SCAN;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      map_q     <= '0;
      ptr_q     <= PTR_TOP;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      ptr_q     <= ptr_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = (state_q != ST_IDLE);
  assign empty   = ~|map_q;

endmodule

// File: tb/tb_flo_bitmap_sched.sv
// Directed bench for flo_bitmap_sched: grant order, scan latency, grant
// stability, set/clear collision, load while presenting, and async reset.
module tb_flo_bitmap_sched;

  localparam int unsigned WID = 576;
  localparam int unsigned IW  = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ld;
  logic [WID-1:0] ld_map;
  logic           set_vld;
  logic [IW-1:0]  set_idx;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_rdy;
  logic           busy;
  logic           empty;

  int checks = 0;
  int errors = 0;

  flo_bitmap_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .ld_map  (ld_map),
    .set_vld (set_vld),
    .set_idx (set_idx),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt_rdy (gnt_rdy),
    .busy    (busy),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Poll for gnt_vld within a cycle budget, then check the granted index.
  task automatic wait_gnt(input string tag, input int exp, input int budget);
    int n;
    n = 0;
    while (!gnt_vld && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 32'(gnt_vld), 32'd1);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(exp));
  endtask

  task automatic do_ld(input logic [WID-1:0] m);
    ld     = 1'b1;
    ld_map = m;
    step();
    ld     = 1'b0;
    ld_map = '0;
  endtask

  task automatic accept_once();
    gnt_rdy = 1'b1;
    step();
    gnt_rdy = 1'b0;
  endtask

  initial begin
    logic [WID-1:0] m;
    rst_n   = 1'b0;
    ld      = 1'b0;
    ld_map  = '0;
    set_vld = 1'b0;
    set_idx = '0;
    gnt_rdy = 1'b0;
    #3;
    chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    #4;
    rst_n = 1'b1;
    step();

    // 1: three bits granted highest first with gnt_rdy held high.
    m = '0; m[5] = 1'b1; m[300] = 1'b1; m[575] = 1'b1;
    gnt_rdy = 1'b1;
    do_ld(m);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_gnt("t1_g575", 575, 8);
    step();
    wait_gnt("t1_g300", 300, 8);
    step();
    wait_gnt("t1_g5", 5, 8);
    step();
    gnt_rdy = 1'b0;
    chk("t1_empty", 32'(empty), 32'd1);
    repeat (4) step();
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: only bit 0 -> four SCAN clocks, grant visible after the fifth edge.
    m = '0; m[0] = 1'b1;
    do_ld(m);
    repeat (3) step();
    chk("t2_vld_early", 32'(gnt_vld), 32'd0);
    step();
    chk("t2_vld", 32'(gnt_vld), 32'd1);
    chk("t2_idx", 32'(gnt_idx), 32'd0);
    accept_once();
    repeat (4) step();
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: grant held stable while a higher bit arrives.
    m = '0; m[100] = 1'b1;
    do_ld(m);
    wait_gnt("t3_g100", 100, 8);
    set_vld = 1'b1;
    set_idx = 10'd500;
    step();
    set_vld = 1'b0;
    repeat (3) step();
    chk("t3_hold_vld", 32'(gnt_vld), 32'd1);
    chk("t3_hold_idx", 32'(gnt_idx), 32'd100);
    accept_once();
    wait_gnt("t3_g500", 500, 8);
    accept_once();
    repeat (4) step();
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: accept of 143 collides with a set of 143; set wins.
    m = '0; m[143] = 1'b1;
    do_ld(m);
    wait_gnt("t4_g143a", 143, 8);
    set_vld = 1'b1;
    set_idx = 10'd143;
    accept_once();
    set_vld = 1'b0;
    chk("t4_vld_drop", 32'(gnt_vld), 32'd0);
    chk("t4_not_empty", 32'(empty), 32'd0);
    wait_gnt("t4_g143b", 143, 8);
    accept_once();
    repeat (4) step();
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: load of all zero while presenting with gnt_rdy low.
    m = '0; m[200] = 1'b1;
    do_ld(m);
    wait_gnt("t5_g200", 200, 8);
    do_ld('0);
    chk("t5_vld_drop", 32'(gnt_vld), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    repeat (3) step();
    chk("t5_busy_scan", 32'(busy), 32'd1);
    step();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);

    // Single-bit set from IDLE: one IDLE clock then the top slice hits.
    set_vld = 1'b1;
    set_idx = 10'd575;
    step();
    set_vld = 1'b0;
    chk("t5s_busy", 32'(busy), 32'd0);
    step();
    chk("t5s_vld_early", 32'(gnt_vld), 32'd0);
    step();
    chk("t5s_vld", 32'(gnt_vld), 32'd1);
    chk("t5s_idx", 32'(gnt_idx), 32'd575);
    accept_once();
    repeat (4) step();

    // 6: asynchronous reset mid-scan, then an out-of-range set is ignored.
    m = '0; m[0] = 1'b1;
    do_ld(m);
    step();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_vld", 32'(gnt_vld), 32'd0);
    chk("t6_rst_idx", 32'(gnt_idx), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    #2;
    rst_n = 1'b1;
    set_vld = 1'b1;
    set_idx = 10'd600;
    step();
    set_vld = 1'b0;
    step();
    chk("t6_oor_empty", 32'(empty), 32'd1);
    chk("t6_oor_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
